fifo_rd_packer: RTL and testbench



---
 rtl/shared_pkg.sv | 15 +
 rtl/fifo_rd_packer.sv | 159 +++++++++++++++
 tb/tb_fifo_rd_packer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
// The packer's optional flush feature is selected with the PACKER_FLUSH_EN macro.
package shared_pkg;

    // Packer control states. Without PACKER_FLUSH_EN the packer stays in RUN permanently.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_OUT  = 2'd2
    } packer_state_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int PACK_DEF       = 2;

endpackage

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO_WIDTH-bit words from a synchronous FIFO and packs
// PACK consecutive words into one wide output word (first popped word in lane 0).
// Optional feature macro: PACKER_FLUSH_EN adds a flush port that emits a
// partial word with out_keep marking the populated lanes.
//
// Output handshake: out_valid/out_data/out_keep are registered. A word
// transfers on every rising edge where out_valid && out_ready. While
// out_valid is high and out_ready is low, out_valid, out_data and out_keep
// hold steady. out_valid never depends combinationally on out_ready.
module fifo_rd_packer
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int PACK       = PACK_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef PACKER_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]      fifo_data_out,
    output logic [FIFO_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output packer_state_e              dbg_state
);

    localparam int            CW        = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);
    localparam int            AW        = FIFO_WIDTH * (PACK - 1);

    logic [CW-1:0]              issue_cnt;
    logic [CW-1:0]              cap_cnt;
    logic                       in_flight;
    logic [AW-1:0]              acc;
    packer_state_e              state;

    logic                       pop;
    logic                       out_fire;
    logic                       capture_last;
    logic                       flush_load;
    logic [FIFO_WIDTH*PACK-1:0] flush_data;
    logic [PACK-1:0]            flush_keep;

    // The last-lane pop is held back while a finished word is still waiting
    // for the sink; pops into earlier lanes only need FIFO data.
    assign pop          = !rst && (state == RUN) && !fifo_empty &&
                          ((issue_cnt != LAST_LANE) || !out_valid || out_ready);
    assign fifo_rd_en   = pop;
    assign out_fire     = out_valid && out_ready;
    assign capture_last = in_flight && (cap_cnt == LAST_LANE);
    assign dbg_state    = state;

`ifdef PACKER_FLUSH_EN
    packer_state_e state_next;

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Flush sequencing: drain the outstanding pop, then emit whatever is
    // accumulated once the output register is free.
    always_comb begin
        state_next = state;
        flush_load = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_next = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!in_flight) begin
                    state_next = (cap_cnt == '0) ? RUN : FLUSH_OUT;
                end
            end
            FLUSH_OUT: begin
                if (!out_valid || out_ready) begin
                    flush_load = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end
`else
    assign state      = RUN;
    assign flush_load = 1'b0;
`endif

    // Partial word for a flush: lanes below cap_cnt carry data, the rest are zero.
    always_comb begin
        flush_data = '0;
        flush_keep = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            if (i < int'(cap_cnt)) begin
                flush_data[i*FIFO_WIDTH +: FIFO_WIDTH] = acc[i*FIFO_WIDTH +: FIFO_WIDTH];
                flush_keep[i]                          = 1'b1;
            end
        end
    end

    // Counters, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            in_flight <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            in_flight <= pop;

            if (flush_load) begin
                issue_cnt <= '0;
            end else if (pop) begin
                issue_cnt <= (issue_cnt == LAST_LANE) ? '0 : issue_cnt + CW'(1);
            end

            if (flush_load) begin
                cap_cnt <= '0;
            end else if (in_flight) begin
                cap_cnt <= (cap_cnt == LAST_LANE) ? '0 : cap_cnt + CW'(1);
            end

            // Lanes are overwritten in place; stale contents are never cleared on wrap.
            for (int i = 0; i < PACK - 1; i++) begin
                if (in_flight && (int'(cap_cnt) == i)) begin
                    acc[i*FIFO_WIDTH +: FIFO_WIDTH] <= fifo_data_out;
                end
            end

            if (capture_last) begin
                out_data  <= {fifo_data_out, acc};
                out_keep  <= '1;
                out_valid <= 1'b1;
            end else if (flush_load) begin
                out_data  <= flush_data;
                out_keep  <= flush_keep;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer (FIFO_WIDTH=16, PACK=2). Models the upstream FIFO
// with a queue and predicts packed words by chunking the popped word stream.
// The flush scenario is compiled in when PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;
  import shared_pkg::*;

  localparam int FW = 16;
  localparam int PK = 2;
  localparam int OW = FW * PK;
  localparam int EW = OW + PK;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fifo_empty = 1'b1;
  logic [FW-1:0]   fifo_data_out = '0;
  logic            out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
  logic            flush = 1'b0;
`endif
  logic            fifo_rd_en;
  logic [OW-1:0]   out_data;
  logic [PK-1:0]   out_keep;
  logic            out_valid;
  packer_state_e   dbg_state;

  logic [FW-1:0]   fifo_q[$];
  logic [FW-1:0]   collect_q[$];
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   sb_entry;

  int n_checks = 0;
  int n_pass = 0;
  int pop_count = 0;
  int accept_count = 0;
  bit pop_pending = 1'b0;
  bit prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic [PK-1:0] prev_keep = '0;

  fifo_rd_packer #(.FIFO_WIDTH(FW), .PACK(PK)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PACKER_FLUSH_EN
    .flush(flush),
`endif
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Every PK popped words in order form one full output word, lane 0 first.
  task automatic model_take(input logic [FW-1:0] w);
    logic [OW-1:0] word;
    collect_q.push_back(w);
    if (collect_q.size() == PK) begin
      word = '0;
      for (int i = 0; i < PK; i++) word[i*FW +: FW] = collect_q[i];
      exp_q.push_back({{PK{1'b1}}, word});
      collect_q.delete();
    end
  endtask

  // Partial emission: collected words in low lanes, keep marks them.
  task automatic model_flush();
    logic [OW-1:0] word;
    logic [PK-1:0] keep;
    word = '0;
    keep = '0;
    if (collect_q.size() > 0) begin
      for (int i = 0; i < collect_q.size(); i++) begin
        word[i*FW +: FW] = collect_q[i];
        keep[i] = 1'b1;
      end
      exp_q.push_back({keep, word});
      collect_q.delete();
    end
  endtask

  // ---------------- FIFO model + scoreboard ----------------
  always @(negedge clk) begin
    pop_pending = fifo_rd_en;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_keep", out_keep, prev_keep);
      end
      if (out_valid && out_ready) begin
        accept_count++;
        check("sb_word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          sb_entry = exp_q.pop_front();
          check("sb_data", out_data, sb_entry[OW-1:0]);
          check("sb_keep", out_keep, sb_entry[EW-1:OW]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // FIFO read data appears the cycle after an accepted pop.
  always @(posedge clk) begin
    logic [FW-1:0] w;
    #1;
    if (pop_pending) begin
      check("pop_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_data_out = w;
        pop_count++;
        model_take(w);
      end
      pop_pending = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit [5:0] rd_seen;
    bit [5:0] v_seen;
    int base;
    int acc_base;
    int pushed;
    bit found;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_state", dbg_state, RUN);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // streaming with ready high
    out_ready = 1'b1;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    rd_seen = '0;
    v_seen = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd_seen[k] = fifo_rd_en;
      v_seen[k] = out_valid;
      if (k == 3) check("stream_word0", out_data, 32'h2222_1111);
      if (k == 5) check("stream_word1", out_data, 32'h4444_3333);
    end
    check("stream_rd_en_pattern", rd_seen, 6'b00_1111);
    check("stream_valid_pattern", v_seen, 6'b10_1000);
    repeat (3) tick();

    // backpressure
    out_ready = 1'b0;
    base = pop_count;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    repeat (8) tick();
    @(negedge clk);
    check("bp_pop_count", pop_count - base, 3);
    check("bp_fifo_left", fifo_q.size(), 1);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 32'h2222_1111);
    check("bp_rd_en_withheld", fifo_rd_en, 0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_valid", out_valid, 1);
    @(negedge clk);
    check("bp_gap_valid", out_valid, 0);
    @(negedge clk);
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 32'h4444_3333);
    repeat (3) tick();

    // empty stall
    base = pop_count;
    push(16'hABCD);
    repeat (6) tick();
    @(negedge clk);
    check("stall_pop_count", pop_count - base, 1);
    check("stall_no_valid", out_valid, 0);
    tick();
    push(16'h1234);
    wait_valid(10, found);
    check("stall_found", found, 1);
    check("stall_data", out_data, 32'h1234_ABCD);
    repeat (3) tick();

    // reset mid-word
    push(16'h5555);
    repeat (4) tick();
    rst = 1'b1;
    collect_q.delete();
    tick();
    push(16'h6666);
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_keep", out_keep, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    push(16'h7777);
    wait_valid(10, found);
    check("mid_rst_found", found, 1);
    check("mid_rst_next_data", out_data, 32'h7777_6666);
    repeat (3) tick();

`ifdef PACKER_FLUSH_EN
    // flush of a partial word
    push(16'h00FF);
    repeat (4) tick();
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    wait_valid(10, found);
    check("flush_found", found, 1);
    check("flush_data", out_data, 32'h0000_00FF);
    check("flush_keep", out_keep, 2'b01);
    repeat (2) tick();
    push(16'hAAAA); push(16'hBBBB);
    wait_valid(10, found);
    check("flush_next_found", found, 1);
    check("flush_next_data", out_data, 32'hBBBB_AAAA);
    check("flush_next_keep", out_keep, 2'b11);
    repeat (3) tick();
`endif

    // randomized traffic with random backpressure
    acc_base = accept_count;
    pushed = 0;
    while (pushed < 220) begin
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0) begin
        push(FW'($urandom));
        pushed++;
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) tick();
    repeat (4) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_fifo_empty", fifo_q.size(), 0);
    check("rand_no_partial", collect_q.size(), 0);
    check("rand_word_count", accept_count - acc_base, 110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
